// File: rtl/y86_seq_controller.sv
// Stage sequencer for the multi-cycle Y86 SEQ core: one-hot stage enables, variable-latency
// data memory handshake, processor status ownership, and cycle/retired-instruction counters.
module y86_seq_controller #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       icode,
  input  logic             instr_valid,
  input  logic             imem_error,
  input  logic             mem_ack,
  input  logic             dmem_error,
  output logic             fetch_en,
  output logic             decode_en,
  output logic             exec_en,
  output logic             mem_req,
  output logic             wb_en,
  output logic             pc_en,
  output logic [1:0]       status,
  output logic             running,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [2:0] StIdle      = 3'd0;
  localparam logic [2:0] StFetch     = 3'd1;
  localparam logic [2:0] StDecode    = 3'd2;
  localparam logic [2:0] StExecute   = 3'd3;
  localparam logic [2:0] StMemory    = 3'd4;
  localparam logic [2:0] StWriteback = 3'd5;
  localparam logic [2:0] StPcUpdate  = 3'd6;
  localparam logic [2:0] StHalted    = 3'd7;

  localparam logic [1:0] StatAok = 2'd0;
  localparam logic [1:0] StatHlt = 2'd1;
  localparam logic [1:0] StatIns = 2'd2;
  localparam logic [1:0] StatAdr = 2'd3;

  localparam int unsigned WaitW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);

  logic [2:0]       state_q, state_d;
  logic [1:0]       status_q, status_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;
  logic [CNT_W-1:0] instr_q, instr_d;
  logic             is_mem_op;

  // mrmovq, rmmovq, call, ret, pushq, popq touch data memory
  assign is_mem_op = (icode == 4'h4) || (icode == 4'h5) || (icode == 4'h8) ||
                     (icode == 4'h9) || (icode == 4'hA) || (icode == 4'hB);

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    wait_d   = '0;
    instr_d  = instr_q;
    cycle_d  = cycle_q;
    if (state_q != StIdle && state_q != StHalted) begin
      cycle_d = cycle_q + CNT_W'(1);
    end
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StFetch;
      end
      StFetch: state_d = StDecode;
      StDecode: begin
        if (imem_error) begin
          status_d = StatAdr;
          state_d  = StHalted;
        end else if (!instr_valid) begin
          status_d = StatIns;
          state_d  = StHalted;
        end else if (icode == 4'h0) begin
          status_d = StatHlt;
          instr_d  = instr_q + CNT_W'(1);
          state_d  = StHalted;
        end else begin
          state_d = StExecute;
        end
      end
      StExecute: state_d = is_mem_op ? StMemory : StWriteback;
      StMemory: begin
        if (mem_ack) begin
          if (dmem_error) begin
            status_d = StatAdr;
            state_d  = StHalted;
          end else begin
            state_d = StWriteback;
          end
        end else if (wait_q == WaitLast) begin
          // wait_q counts completed no-ack cycles; this is the last one allowed
          status_d = StatAdr;
          state_d  = StHalted;
        end else begin
          wait_d = wait_q + WaitW'(1);
        end
      end
      StWriteback: state_d = StPcUpdate;
      StPcUpdate: begin
        instr_d = instr_q + CNT_W'(1);
        state_d = StFetch;
      end
      StHalted: state_d = StHalted;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      status_q <= StatAok;
      wait_q   <= '0;
      cycle_q  <= '0;
      instr_q  <= '0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      wait_q   <= wait_d;
      cycle_q  <= cycle_d;
      instr_q  <= instr_d;
    end
  end

  // Outputs decode straight from the state register, so async reset clears them at once
  always_comb begin
    fetch_en  = (state_q == StFetch);
    decode_en = (state_q == StDecode);
    exec_en   = (state_q == StExecute);
    mem_req   = (state_q == StMemory);
    wb_en     = (state_q == StWriteback);
    pc_en     = (state_q == StPcUpdate);
    running   = (state_q != StIdle) && (state_q != StHalted);
  end

  assign status      = status_q;
  assign cycle_count = cycle_q;
  assign instr_count = instr_q;

endmodule

// File: tb/tb_y86_seq_controller.sv
// Directed bench for y86_seq_controller; a CNT_W=4 twin on the same inputs covers counter wrap.
module tb_y86_seq_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  icode;
  logic        instr_valid;
  logic        imem_error;
  logic        mem_ack;
  logic        dmem_error;
  logic        fetch_en, decode_en, exec_en, mem_req, wb_en, pc_en, running;
  logic [1:0]  status;
  logic [31:0] cycle_count, instr_count;
  logic        f4, d4, e4, m4, w4, p4, r4;
  logic [1:0]  s4;
  logic [3:0]  cyc4, ins4;

  int total = 0;
  int bad   = 0;
  int nreq;
  logic seen_wbpc;

  always #5 clk = ~clk;

  y86_seq_controller #(.CNT_W(32), .MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .icode(icode), .instr_valid(instr_valid),
    .imem_error(imem_error), .mem_ack(mem_ack), .dmem_error(dmem_error),
    .fetch_en(fetch_en), .decode_en(decode_en), .exec_en(exec_en), .mem_req(mem_req),
    .wb_en(wb_en), .pc_en(pc_en), .status(status), .running(running),
    .cycle_count(cycle_count), .instr_count(instr_count)
  );

  y86_seq_controller #(.CNT_W(4), .MEM_TIMEOUT(16)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .icode(icode), .instr_valid(instr_valid),
    .imem_error(imem_error), .mem_ack(mem_ack), .dmem_error(dmem_error),
    .fetch_en(f4), .decode_en(d4), .exec_en(e4), .mem_req(m4),
    .wb_en(w4), .pc_en(p4), .status(s4), .running(r4),
    .cycle_count(cyc4), .instr_count(ins4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {fetch, decode, exec, mem_req, wb, pc}
  function automatic logic [31:0] ens();
    return {26'd0, fetch_en, decode_en, exec_en, mem_req, wb_en, pc_en};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0; icode = 4'h6; instr_valid = 1'b1; imem_error = 1'b0;
    mem_ack = 1'b0; dmem_error = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // From FETCH, run one OPq through to the next FETCH
  task automatic run_opq();
    icode = 4'h6;
    repeat (5) step();
  endtask

  initial begin
    do_reset();
    check("reset_en", ens(), 32'h0);
    check("reset_run", {31'd0, running}, 32'd0);
    check("reset_status", {30'd0, status}, 32'd0);
    check("reset_cycles", cycle_count, 32'd0);
    check("reset_instrs", instr_count, 32'd0);

    // OPq: five one-hot stages
    start = 1'b1; step(); start = 1'b0;
    check("op_fetch", ens(), 32'h20);
    step(); check("op_decode", ens(), 32'h10);
    step(); check("op_exec", ens(), 32'h08);
    step(); check("op_wb", ens(), 32'h02);
    step(); check("op_pc", ens(), 32'h01);
    step(); check("op_refetch", ens(), 32'h20);
    check("op_cycles", cycle_count, 32'd5);
    check("op_instrs", instr_count, 32'd1);
    check("op_status", {30'd0, status}, 32'd0);

    // mrmovq with ack on the 4th MEMORY cycle
    icode = 4'h5;
    step(); step();
    check("mr_exec", ens(), 32'h08);
    step(); check("mr_mem1", ens(), 32'h04);
    step(); check("mr_mem2", ens(), 32'h04);
    step(); check("mr_mem3", ens(), 32'h04);
    step(); check("mr_mem4", ens(), 32'h04);
    mem_ack = 1'b1;
    step(); mem_ack = 1'b0;
    check("mr_wb", ens(), 32'h02);
    step(); check("mr_pc", ens(), 32'h01);
    step();
    check("mr_cycles", cycle_count, 32'd14);
    check("mr_instrs", instr_count, 32'd2);
    check("mr_status", {30'd0, status}, 32'd0);

    // Two OPq then halt; stray ack/error outside MEMORY must be ignored
    do_reset();
    mem_ack = 1'b1; dmem_error = 1'b1;
    start = 1'b1; step(); start = 1'b0;
    run_opq(); run_opq();
    check("h_stray_status", {30'd0, status}, 32'd0);
    mem_ack = 1'b0; dmem_error = 1'b0;
    icode = 4'h0;
    step(); check("h_decode", ens(), 32'h10);
    step();
    check("h_status", {30'd0, status}, 32'd1);
    check("h_run", {31'd0, running}, 32'd0);
    check("h_en", ens(), 32'h0);
    check("h_instrs", instr_count, 32'd3);
    check("h_cycles", cycle_count, 32'd12);
    start = 1'b1; step(); step(); start = 1'b0;
    check("h_start_ign_en", ens(), 32'h0);
    check("h_start_ign_cyc", cycle_count, 32'd12);
    check("h_start_ign_st", {30'd0, status}, 32'd1);

    // imem_error wins over instr_valid=0
    do_reset();
    start = 1'b1; step(); start = 1'b0;
    imem_error = 1'b1; instr_valid = 1'b0;
    step(); step();
    check("adr_status", {30'd0, status}, 32'd3);
    check("adr_instrs", instr_count, 32'd0);
    check("adr_run", {31'd0, running}, 32'd0);

    do_reset();
    start = 1'b1; step(); start = 1'b0;
    instr_valid = 1'b0;
    step(); step();
    check("ins_status", {30'd0, status}, 32'd2);
    check("ins_instrs", instr_count, 32'd0);

    // pushq with no ack: exactly MEM_TIMEOUT request cycles, then ADR
    do_reset();
    icode = 4'hA;
    start = 1'b1; step(); start = 1'b0;
    step(); step(); step();
    nreq = 0; seen_wbpc = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (mem_req) nreq++;
      if (wb_en || pc_en) seen_wbpc = 1'b1;
      step();
    end
    check("to_req_cycles", nreq, 32'd16);
    check("to_no_wbpc", {31'd0, seen_wbpc}, 32'd0);
    check("to_status", {30'd0, status}, 32'd3);
    check("to_instrs", instr_count, 32'd0);

    // rmmovq, ack with error on first MEMORY cycle
    do_reset();
    icode = 4'h4;
    start = 1'b1; step(); start = 1'b0;
    step(); step(); step();
    check("de_mem", ens(), 32'h04);
    mem_ack = 1'b1; dmem_error = 1'b1;
    step(); mem_ack = 1'b0; dmem_error = 1'b0;
    check("de_status", {30'd0, status}, 32'd3);
    check("de_en", ens(), 32'h0);

    // Async reset mid-MEMORY drops mem_req before the next edge
    do_reset();
    icode = 4'h5;
    start = 1'b1; step(); start = 1'b0;
    step(); step(); step(); step();
    check("ar_mem_before", ens(), 32'h04);
    #2 rst_n = 1'b0;
    #1;
    check("ar_mem_req", {31'd0, mem_req}, 32'd0);
    check("ar_run", {31'd0, running}, 32'd0);
    check("ar_cycles", cycle_count, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("ar_idle_en", ens(), 32'h0);

    // 4-bit counter twin wraps 15 -> 0
    do_reset();
    start = 1'b1; step(); start = 1'b0;
    run_opq(); run_opq(); run_opq();
    check("w_cyc15", {28'd0, cyc4}, 32'd15);
    run_opq();
    check("w_cyc_wrap", {28'd0, cyc4}, 32'd4);
    check("w_ins4", {28'd0, ins4}, 32'd4);
    check("w_cyc32", cycle_count, 32'd20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
